regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: the ALU result path and the memory load path. Round-robin arbitration runs over valid/ready handshakes. The accepted result is registered onto the RegWrite/RD/WriteData port, and the register file commits it on the following negedge. A 32-entry busy scoreboard tracks destinations with an in-flight producer so the issue stage can stall on RAW hazards.

Parameters:
XLEN, 64, data width of WriteData and requester data
NREG, 32, number of architectural registers (busy vector width)
AW, 5, register index width
MEM_FIRST, 0, 1 = memory requester wins the first contested cycle after reset; 0 = ALU wins

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU writeback request
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load writeback request
mem_rd  input  AW  load destination register
mem_data  input  XLEN  load data
mem_ready  output  1  load request accepted this cycle
issue_valid  input  1  instruction issued with a register destination
issue_rd  input  AW  destination of the issued instruction
rs1  input  AW  source index query 1
rs2  input  AW  source index query 2
rs1_busy  output  1  rs1 has a pending producer
rs2_busy  output  1  rs2 has a pending producer
RegWrite  output  1  write enable to register file
RD  output  AW  write index to register file
WriteData  output  XLEN  write data to register file
busy  output  NREG  scoreboard vector

Behaviour:
- Reset, synchronous: RegWrite=0, RD=0, WriteData=0, busy=0. last_grant is set so the requester selected by MEM_FIRST wins the next contest. alu_ready=mem_ready=0 while reset is high.
- Grant, combinational, at most one per cycle:
  - only alu_valid → ALU
  - only mem_valid → MEM
  - both valid → the requester not granted most recently
  - neither valid → no grant
- alu_ready = grant_alu; mem_ready = grant_mem. Ready is never high without the matching valid.
- A transfer is valid&&ready at a posedge. The requester must hold rd/data stable while valid is high and ready is low.
- last_grant updates only on a transfer. It is unchanged in idle cycles and in uncontested cycles, except that the winner is recorded.
- Output register, 1-cycle latency: on a transfer edge, RegWrite=(rd!=0), RD=rd, WriteData=data. With no transfer, RegWrite=0 and RD/WriteData hold their previous values.
- The register file writes on the negedge of the cycle in which RegWrite is high, giving one full write per accepted request.
- x0: a transfer with rd=0 is accepted (ready high, last_grant updates), but RegWrite stays 0. busy[0] is never set.
- Scoreboard, evaluated at each posedge:
  - issue_valid && issue_rd!=0 sets busy[issue_rd]
  - a transfer with rd!=0 clears busy[rd]
  - same edge, same index for set and clear → set wins, because the new producer supersedes the old one
  - set and clear on different indices both take effect
- rsN_busy = busy[rsN]; always 0 for rsN=0. Combinational, no bypass of a same-cycle clear.
- A write to a register whose busy bit is already 0 is still performed; the scoreboard does not block writes.
- Synchronous reset mid-stream drops any request presented in the reset cycle (ready low) and clears RegWrite on that edge. The pending register-file write from the previous cycle still occurs on the reset cycle's negedge.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=64'h1234 for one cycle → alu_ready=1 that cycle; next cycle RegWrite=1, RD=5, WriteData=64'h1234; following cycle RegWrite=0.
- Both valid for 4 cycles with MEM_FIRST=0 (alu_rd=1, mem_rd=2), each side dropping valid after its accept → grants ALU, MEM, ALU, MEM; RD sequence 1,2,1,2; never both ready in one cycle.
- issue_valid with issue_rd=7, then rs1=7 → busy[7]=1, rs1_busy=1. A later mem transfer with mem_rd=7 → busy[7]=0 after that edge; RegWrite=1, RD=7 next cycle.
- Same edge: issue_rd=9 and ALU transfer with alu_rd=9, busy[9] previously 1 → busy[9] stays 1; the write to reg 9 still goes out with RegWrite=1.
- alu_valid with alu_rd=0 and data 64'hFF → alu_ready=1, RegWrite stays 0. issue_rd=0 → busy stays 0, and rs2=0 gives rs2_busy=0.
- Both valid, reset asserted for one cycle → both ready=0 and RegWrite=0 after the edge, busy=0. The contest after reset goes to ALU (MEM_FIRST=0).

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load
// writeback paths, with a busy scoreboard for RAW-hazard stalls at issue.
module regfile_wb_arbiter #(
    parameter int XLEN      = 64,
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter bit MEM_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            RegWrite,
    output logic [AW-1:0]   RD,
    output logic [XLEN-1:0] WriteData,
    output logic [NREG-1:0] busy
);

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

    gnt_e            last_grant_q, last_grant_d;
    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            grant_alu, grant_mem, xfer;
    logic [AW-1:0]   xfer_rd;
    logic [XLEN-1:0] xfer_data;

    // Contested cycles go to whoever did not win last; reset blocks all grants.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!reset) begin
            if (alu_valid && mem_valid) begin
                if (last_grant_q == GNT_MEM) grant_alu = 1'b1;
                else                         grant_mem = 1'b1;
            end else if (alu_valid) begin
                grant_alu = 1'b1;
            end else if (mem_valid) begin
                grant_mem = 1'b1;
            end
        end
    end

    assign xfer      = grant_alu | grant_mem;
    assign xfer_rd   = grant_mem ? mem_rd   : alu_rd;
    assign xfer_data = grant_mem ? mem_data : alu_data;

    always_comb begin
        last_grant_d = last_grant_q;
        regwrite_d   = 1'b0;
        rd_d         = rd_q;
        wdata_d      = wdata_q;
        busy_d       = busy_q;
        if (grant_mem)      last_grant_d = GNT_MEM;
        else if (grant_alu) last_grant_d = GNT_ALU;
        if (xfer) begin
            regwrite_d = (xfer_rd != '0);
            rd_d       = xfer_rd;
            wdata_d    = xfer_data;
            if (xfer_rd != '0) busy_d[xfer_rd] = 1'b0;
        end
        // Applied after the clear so a fresh producer supersedes the retiring one.
        if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= MEM_FIRST ? GNT_ALU : GNT_MEM;
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;
    assign RegWrite  = regwrite_q;
    assign RD        = rd_q;
    assign WriteData = wdata_q;
    assign busy      = busy_q;
    assign rs1_busy  = (rs1 != '0) && busy_q[rs1];
    assign rs2_busy  = (rs2 != '0) && busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at each accepted
// request and popped when the registered write port should show them.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
    logic [63:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rs1_busy, rs2_busy, RegWrite;
    logic [4:0]  RD;
    logic [63:0] WriteData;
    logic [31:0] busy;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;
    logic [63:0] rf [32] = '{default: 64'h0};

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .busy(busy)
    );

    // Register-file model: commits on the negedge of a cycle with RegWrite high.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) rf[RD] <= WriteData;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus, check the write port and readies at the negedge,
    // then advance to just after the next posedge.
    task automatic step(input logic r,
                        input logic av, input logic [4:0] ard, input logic [63:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                        input logic iv, input logic [4:0] ird,
                        input logic exp_ar, input logic exp_mr);
        wr_t e;
        reset = r;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        issue_valid = iv; issue_rd = ird;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("regwrite", 64'(RegWrite), 64'd1);
            chk("rd", 64'(RD), 64'(e.rd));
            chk("wdata", WriteData, e.data);
        end else begin
            chk("regwrite_idle", 64'(RegWrite), 64'd0);
        end
        chk("alu_ready", 64'(alu_ready), 64'(exp_ar));
        chk("mem_ready", 64'(mem_ready), 64'(exp_mr));
        if (exp_ar && ard != 5'd0) exp_q.push_back('{rd: ard, data: ad});
        if (exp_mr && mrd != 5'd0) exp_q.push_back('{rd: mrd, data: md});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] n);
        for (int i = 0; i < int'(n); i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rs1 = 5'd0; rs2 = 5'd0;
        // Reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_rd", 64'(RD), 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Single ALU writeback, then idle
        step(0, 1, 5, 64'h1234, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Mem-only transfer leaves MEM as last winner, so the contest starts with ALU
        step(0, 0, 0, 0, 1, 3, 64'h33, 0, 0, 0, 1);
        step(0, 1, 1, 64'hA1, 1, 2, 64'hB1, 0, 0, 1, 0);
        step(0, 1, 1, 64'hA2, 1, 2, 64'hB1, 0, 0, 0, 1);
        step(0, 1, 1, 64'hA2, 1, 2, 64'hB2, 0, 0, 1, 0);
        step(0, 1, 1, 64'hA3, 1, 2, 64'hB2, 0, 0, 0, 1);
        idle(1);

        // Scoreboard set by issue, cleared by the matching load writeback
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        rs1 = 5'd7; #1;
        chk("busy7_set", 64'(busy[7]), 64'd1);
        chk("rs1_busy7", 64'(rs1_busy), 64'd1);
        step(0, 0, 0, 0, 1, 7, 64'h77, 0, 0, 0, 1);
        chk("busy7_clr", 64'(busy[7]), 64'd0);
        chk("rs1_busy7_clr", 64'(rs1_busy), 64'd0);
        idle(1);

        // Same-edge set and clear on reg 9: the set wins, the write still goes out
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        chk("busy9_set", 64'(busy), 64'h200);
        step(0, 1, 9, 64'h99, 0, 0, 0, 1, 9, 1, 0);
        chk("busy9_keep", 64'(busy), 64'h200);
        idle(1);

        // x0: accepted, never written, never busy
        step(0, 1, 0, 64'hFF, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rs2 = 5'd0; #1;
        chk("busy_x0", 64'(busy), 64'h200);
        chk("rs2_busy_x0", 64'(rs2_busy), 64'd0);
        rs2 = 5'd9; #1;
        chk("rs2_busy9", 64'(rs2_busy), 64'd1);
        idle(1);

        // Mid-stream reset: previous write still lands, requests in the reset cycle drop
        step(0, 1, 4, 64'h44, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 11, 64'hC1, 1, 12, 64'hD1, 1, 11, 0, 0);
        chk("mrst_regwrite", 64'(RegWrite), 64'd0);
        chk("mrst_rd", 64'(RD), 64'd0);
        chk("mrst_wdata", WriteData, 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        step(0, 1, 11, 64'hC1, 1, 12, 64'hD1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 12, 64'hD1, 0, 0, 0, 1);
        idle(2);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // Register-file contents: one committed write per accepted nonzero request
        chk("rf0", rf[0], 64'h0);
        chk("rf1", rf[1], 64'hA2);
        chk("rf2", rf[2], 64'hB2);
        chk("rf3", rf[3], 64'h33);
        chk("rf4", rf[4], 64'h44);
        chk("rf5", rf[5], 64'h1234);
        chk("rf7", rf[7], 64'h77);
        chk("rf9", rf[9], 64'h99);
        chk("rf11", rf[11], 64'hC1);
        chk("rf12", rf[12], 64'hD1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
